// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the MIPS inter-stage pipeline registers.
//   - state_t       : occupancy state of a skid stage (EMPTY / ONE / TWO)
//   - MEMWB_*       : MEM/WB payload field widths and bit offsets, used by every
//                     stage that packs or unpacks that boundary's payload.
// Control fields sit in the payload LSBs so a stage can clear them with a
// simple low-order mask.
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // MEM/WB field widths
    localparam int MEMWB_REGWRITE_W   = 1;
    localparam int MEMWB_CACHETOREG_W = 2;
    localparam int MEMWB_READ_DATA_W  = 32;
    localparam int MEMWB_ALU_RESULT_W = 32;
    localparam int MEMWB_INC_PC_W     = 32;
    localparam int MEMWB_WRITEREG_W   = 5;

    // MEM/WB field offsets (LSB of each field)
    localparam int MEMWB_REGWRITE_LSB   = 0;
    localparam int MEMWB_CACHETOREG_LSB = MEMWB_REGWRITE_LSB   + MEMWB_REGWRITE_W;
    localparam int MEMWB_READ_DATA_LSB  = MEMWB_CACHETOREG_LSB + MEMWB_CACHETOREG_W;
    localparam int MEMWB_ALU_RESULT_LSB = MEMWB_READ_DATA_LSB  + MEMWB_READ_DATA_W;
    localparam int MEMWB_INC_PC_LSB     = MEMWB_ALU_RESULT_LSB + MEMWB_ALU_RESULT_W;
    localparam int MEMWB_WRITEREG_LSB   = MEMWB_INC_PC_LSB     + MEMWB_INC_PC_W;

    // Control bits (RegWrite + CachetoReg) and full payload width
    localparam int MEMWB_CTRL_W = MEMWB_REGWRITE_W + MEMWB_CACHETOREG_W;
    localparam int MEMWB_W      = MEMWB_WRITEREG_LSB + MEMWB_WRITEREG_W;

endpackage

// File: rtl/mips_pipe_stall_cnt.sv
// -----------------------------------------------------------------------------
// mips_pipe_stall_cnt
// Saturating up-counter of backpressure cycles. Holds at all-ones instead of
// wrapping; cleared only by reset.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   inc   : count this cycle
//   count : current count (CNT_W bits)
// -----------------------------------------------------------------------------
module mips_pipe_stall_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mips_pipe_skid_stage.sv
// -----------------------------------------------------------------------------
// mips_pipe_skid_stage
// Width-generic MIPS pipeline stage register with valid/ready handshake and a
// 2-entry skid buffer (main + skid), giving full throughput under
// backpressure with a purely registered in_ready_o.
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid_i/in_ready_o : upstream handshake
//   in_data_i             : payload, control bits in [CTRL_W-1:0]
//   out_valid_o/out_ready_i : downstream handshake
//   out_data_o            : payload (control bits read 0 while out_valid_o=0)
//   hold_i                : legacy cache stall, behaves as out_ready_i=0
//   flush_i               : empty the stage and clear stored control bits
//   stall_cnt_o           : saturating backpressure cycle count
// Build option: define MIPS_PIPE_STALL_CNT_EN to include the stall counter;
// otherwise stall_cnt_o is tied to 0.
// -----------------------------------------------------------------------------
module mips_pipe_skid_stage
    import mips_pipe_pkg::*;
#(
    parameter int DATA_W = MEMWB_W,
    parameter int CTRL_W = MEMWB_CTRL_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    // Ones in the control-field positions; all zero when CTRL_W == 0.
    localparam logic [DATA_W-1:0] CTRL_MASK = {DATA_W{1'b1}} >> (DATA_W - CTRL_W);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] main_data, main_nxt;
    logic [DATA_W-1:0] skid_data, skid_nxt;
    logic              deq, enq;

    assign deq = out_valid_o & out_ready_i & ~hold_i;
    assign enq = in_valid_i & in_ready_o;

    // State and payload registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            // NOTE: payload flops are reset because out_data_o must read 0 after
            // reset; a large storage array would normally be left unreset.
            main_data <= '0;
            skid_data <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state     <= state_nxt;
            main_data <= main_nxt;
            skid_data <= skid_nxt;
        end
    end

    // Next-state and next-payload logic
    always_comb begin
        // NOTE: hold-current defaults first, so no branch can infer a latch.
        state_nxt = state;
        main_nxt  = main_data;
        skid_nxt  = skid_data;

        if (flush_i) begin
            // Any enq is dropped; a concurrent deq has already been taken
            // downstream, so emptying the stage is correct either way.
            state_nxt = ST_EMPTY;
            main_nxt  = main_data & ~CTRL_MASK;
            skid_nxt  = skid_data & ~CTRL_MASK;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (enq) begin
                        state_nxt = ST_ONE;
                        main_nxt  = in_data_i;
                    end
                end
                ST_ONE: begin
                    if (enq && deq) begin
                        main_nxt = in_data_i;
                    end else if (enq) begin
                        state_nxt = ST_TWO;
                        skid_nxt  = in_data_i;
                    end else if (deq) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // in_ready_o is low here, so only the skid entry moves up.
                    if (deq) begin
                        state_nxt = ST_ONE;
                        main_nxt  = skid_data;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Outputs: decoded from the state flops only, so ready is registered.
    always_comb begin
        out_valid_o = (state != ST_EMPTY);
        in_ready_o  = (state != ST_TWO);
        out_data_o  = out_valid_o ? main_data : (main_data & ~CTRL_MASK);
    end

`ifdef MIPS_PIPE_STALL_CNT_EN
    logic stall;
    assign stall = out_valid_o & (~out_ready_i | hold_i);

    mips_pipe_stall_cnt #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall),
        .count (stall_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/mips_pipe_skid_stage.md
Name: mips_pipe_skid_stage

Overview:
- Parametrised pipeline stage register for the MIPS pipeline. It generalises the fixed-field, stall-only inter-stage latch to a width-generic payload.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, synchronous flush with control-field clearing, and a legacy hold input.
- Drop-in for the IF/ID, ID/EX, EX/MEM and MEM/WB boundaries, e.g. when fronting the L2 cache path.

Parameters:
- DATA_W, 104, total payload width (MEM/WB: RegWrite 1 + CachetoReg 2 + Read_data 32 + ALU_result 32 + incremented_PC 32 + WriteReg 5).
- CTRL_W, 3, number of payload LSBs that are control bits, zeroed on flush/bubble; 0 ≤ CTRL_W ≤ DATA_W.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low
- in_valid_i  input  1  upstream payload valid
- in_ready_o  output  1  stage can accept a payload
- in_data_i  input  DATA_W  payload; control bits in [CTRL_W-1:0]
- out_valid_o  output  1  downstream payload valid
- out_ready_i  input  1  downstream accepts
- out_data_o  output  DATA_W  payload
- hold_i  input  1  legacy cache-stall; acts as forced out_ready_i=0
- flush_i  input  1  discard all held payloads
- stall_cnt_o  output  CNT_W  backpressure cycle count (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at posedge clk): both entries invalid; out_valid_o=0, in_ready_o=1, out_data_o=0, skid data=0, stall_cnt_o=0. Reset overrides every other input and aborts any held payload.
- Internal signals:
  - deq = out_valid_o & out_ready_i & ~hold_i
  - enq = in_valid_i & in_ready_o
- Storage: main register (drives out_*) and skid register. in_ready_o = ~skid_valid, registered, so there is no combinational in→out ready path.
- States (2-bit): EMPTY, ONE (main valid), TWO (main + skid valid).
  - EMPTY: enq → ONE; data goes to main. Latency is 1 cycle, in_data_i to out_data_o.
  - ONE: enq & deq → ONE (main ← in); enq & ~deq → TWO (skid ← in); ~enq & deq → EMPTY; else hold.
  - TWO: in_ready_o=0. deq → ONE (main ← skid); else hold.
- Ordering is strict FIFO. No payload is ever dropped or duplicated.
- Throughput: 1 payload/cycle when out_ready_i=1 and hold_i=0.
- Flush (flush_i=1, rst_n=1): next state EMPTY.
  - main and skid control fields [CTRL_W-1:0] cleared to 0; data fields retained.
  - A simultaneous enq is discarded; a simultaneous deq completes as a normal handshake.
  - Flush beats hold.
- Hold (hold_i=1): no deq, so state and data are frozen unless enq fills the skid. The MWWrite semantics are preserved when the upstream also stalls.
- Bubble: when out_valid_o=0, out_data_o control bits read 0, so a consumer ignoring valid still sees RegWrite=0.
- CTRL_W=0: flush/bubble clearing is a no-op.

Optional Feature:
- Macro: MIPS_PIPE_STALL_CNT_EN.
- With the macro: stall_cnt_o increments each cycle with out_valid_o & (~out_ready_i | hold_i).
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared by reset only; flush does not clear it.
- Without the macro: stall_cnt_o is tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package mips_pipe_pkg:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2
  - MEM/WB field width constants and payload bit offsets, shared by all instantiating stages
- One natural sub-module: mips_pipe_stall_cnt (saturating counter), instantiated only under MIPS_PIPE_STALL_CNT_EN.

Test Plan:
- Reset mid-traffic: state TWO, rst_n=0 one cycle → out_valid_o=0, in_ready_o=1, out_data_o=0, stall_cnt_o=0.
- Streaming: in_valid_i=1 for 8 cycles with data 1..8, out_ready_i=1 → out_data_o=1..8 on consecutive cycles, 1-cycle latency, in_ready_o constantly 1.
- Backpressure/skid: send A, B with out_ready_i=0 → state TWO, in_ready_o=0; C offered is not accepted; release ready → A, B, C delivered in order with no loss.
- Hold: hold_i=1 with out_ready_i=1 for 5 cycles holding payload 0xDEAD → out_data_o stays 0xDEAD and out_valid_o=1; with the macro, stall_cnt_o=5.
- Flush: state TWO, payload control bits 3'b111; flush_i=1 with in_valid_i=1 → next cycle EMPTY, out_valid_o=0, out_data_o[2:0]=0, new input discarded.
- Saturation (CNT_W=4, macro on): out_ready_i=0 for 20 cycles with out_valid_o=1 → stall_cnt_o=15 and stays 15.
